// File: rtl/alu_mc.sv
// Multi-cycle RISC-V ALU: single-cycle logic/arith ops plus iterative mul/divu/remu.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul/divu/remu.
// Backpressure: Start is ignored while Busy=1; Done pulses once per accepted op.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op;
  // mul: opa = shifted multiplicand, opb = shifted multiplier, acc = product
  // div: opa = dividend / quotient shift register, opb = divisor, acc = remainder
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] single_res;
  logic             iterative;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic [WIDTH-1:0] iter_res;

  always_comb begin
    shamt      = SrcB[SW-1:0];
    single_res = '0;
    case (ALUControl)
      OP_ADD:  single_res = SrcA + SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = $signed(SrcA) >>> shamt;
      default: single_res = '0;
    endcase
    iterative = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
  end

  // One iteration step; the final step's output is registered straight into ALUResult.
  always_comb begin
    mul_acc_nxt = opb[0] ? acc + opa : acc;
    div_shift   = {acc, opa[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opb};
    div_qbit    = ~div_diff[WIDTH];
    div_rem_nxt = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nxt = {opa[WIDTH-2:0], div_qbit};
    case (op)
      OP_MUL:  iter_res = mul_acc_nxt;
      OP_DIVU: iter_res = div_quo_nxt;
      default: iter_res = div_rem_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op <= ALUControl;
            if (iterative) begin
              opa   <= SrcA;
              opb   <= SrcB;
              acc   <= '0;
              cnt   <= CW'(WIDTH);
              Busy  <= 1'b1;
              state <= RUN;
            end else begin
              ALUResult <= single_res;
              Zero      <= (single_res == '0);
              Done      <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op == OP_MUL) begin
            acc <= mul_acc_nxt;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= div_rem_nxt;
            opa <= div_quo_nxt;
          end
          if (cnt == CW'(1)) begin
            ALUResult <= iter_res;
            Zero      <= (iter_res == '0);
            Done      <= 1'b1;
            state     <= FIN;
          end
        end
        FIN: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V datapath, the successor of the single-cycle combinational ALU. It adds xor, unsigned compare, shifts, and iterative multiply/divide/remainder behind a Start/Busy/Done handshake. Results are registered. Operand width is set by `WIDTH`. It sits in the execute stage and is used by the multi-cycle control unit, which stalls on `Busy`.

## Interface
- `WIDTH`, 32: operand/result width in bits. Must be a power of two, ≥ 8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Start` in 1: request an operation. Accepted only when `Busy`=0.
- `SrcA` in WIDTH: first operand, sampled at acceptance.
- `SrcB` in WIDTH: second operand, sampled at acceptance.
- `ALUControl` in 4: operation select, sampled at acceptance.
- `Busy` out 1: iterative operation in progress.
- `Done` out 1: one-cycle pulse; `ALUResult` valid and updated.
- `ALUResult` out WIDTH: registered result, held until the next `Done`.
- `Zero` out 1: registered; 1 when `ALUResult` == 0.

## Operation
- Encodings (codes 0000–0011 and 0101 match the existing single-cycle ALU):
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed)
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1010 mul (low WIDTH bits)
  - 1011 divu
  - 1100 remu
  - 1101–1111: result 0, single-cycle.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- slt/sltu produce a result in bit 0 with all other bits 0.
- Shift amount is `SrcB[log2(WIDTH)-1:0]`; upper bits are ignored.
- FSM states:
  - IDLE: on `Start`, latch operands and op.
    - Single-cycle op: compute, register the result, pulse `Done`; stay in IDLE.
    - Iterative op (1010–1100): load counter = WIDTH and go to RUN.
  - RUN: one iteration per cycle.
    - mul: shift-add, one multiplier bit per cycle, LSB first.
    - divu/remu: restoring division, one quotient bit per cycle, MSB first.
    - Counter decrements each cycle; at 0, go to FIN.
  - FIN: register the result (product low, quotient, or remainder), pulse `Done`, return to IDLE.
- Divide by zero (`SrcB`=0):
  - divu gives all-ones; remu gives `SrcA`.
  - Still takes the full iterative latency; no exception.
- `Start` while `Busy`=1 is ignored; the in-flight operation is unaffected.
- Input changes after acceptance have no effect.

## Timing
- Reset values: `Busy`=0, `Done`=0, `ALUResult`=0, `Zero`=1; FSM in IDLE; counter 0.
- Let T be the rising edge where `Start`=1 is sampled in IDLE.
- Single-cycle ops:
  - `Done`=1 and new `ALUResult`/`Zero` during the cycle after T (latency 1).
  - `Busy` stays 0.
- Iterative ops:
  - `Busy`=1 from T+1 through T+WIDTH+1, i.e. during RUN and FIN.
  - `Done`=1 together with the new result in the FIN cycle, WIDTH+1 cycles after T.
  - `Busy` falls to 0 on the edge where FIN returns to IDLE (T+WIDTH+2).
- Back-to-back:
  - `Start` may be asserted in the cycle following a `Done`.
  - With single-cycle ops, one result per cycle is sustained.
- `Done` is high for exactly one cycle per accepted operation. `ALUResult` changes only in `Done` cycles.
- Reset asserted mid-operation:
  - Immediate abort to reset values.
  - No `Done` for the aborted operation.
  - A `Start` on the first edge after reset deassertion is accepted.

## Test plan
- Wrap-around: add 0xFFFFFFFF+1 → `ALUResult`=0, `Zero`=1, `Done` 1 cycle after Start. Sub 0−1 → 0xFFFFFFFF.
- Signed vs unsigned compare: SrcA=0xFFFFFFFF, SrcB=1 → slt=1, sltu=0. sra of 0x80000000 by 36 (amount 4) → 0xF8000000.
- Multiply: 0x0001_0003 × 0x0002_0005 → 0x000B_000F. `Busy` high for 33 cycles. `Done` exactly 33 cycles after Start (WIDTH+1). Back-to-back Start after `Done` is accepted.
- Divide: divu 100/7 → 14; remu → 2. Divide by zero: divu 5/0 → 0xFFFFFFFF, remu 5/0 → 5, same latency.
- Start while busy: issue mul, then pulse Start with add during RUN → ignored; single `Done` with the mul result only.
- Reset mid-mul (cycle 10 of RUN): outputs reset values immediately, no `Done`. A new add issued after reset completes in 1 cycle.
